// File: rtl/mem_access_unit_if.sv
// Request/acknowledge data bus between the memory-stage controller and the data memory.
interface mem_access_unit_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    modport master (output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
                    input  bus_ack, bus_rdata);
    modport slave  (input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
                    output bus_ack, bus_rdata);
endinterface

// File: rtl/mem_access_unit.sv
// Memory-stage access controller: runs one req/ack bus transaction per load/store,
// stalls the pipeline meanwhile, and returns aligned, extended load data.
module mem_access_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_in,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        byte_op,
    input  logic        half,
    input  logic        unsigned_ext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        done,
    output logic [31:0] rdata_out,
    output logic        misalign,
    output logic        bus_err,
    mem_access_unit_if.master bus
);
    typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;
    state_t state, state_nxt;

    logic        access, mis, go, timeout;
    logic        l_we, l_rd, l_byte, l_half, l_uns, err_q;
    logic [1:0]  l_off;
    logic [7:0]  cnt;
    logic [31:0] addr_q, wdata_q, ld_ext;
    logic [3:0]  be_q;
    logic [7:0]  ld_b;
    logic [15:0] ld_h;

    assign access   = valid_in & (mem_read | mem_write);
    assign mis      = (half & addr[0]) | (~byte_op & ~half & (addr[1:0] != 2'b00));
    assign misalign = (state == IDLE) & access & mis;
    assign go       = (state == IDLE) & access & ~mis;
    assign timeout  = (cnt == 8'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        case (state)
            IDLE: if (go) begin
                stall     = 1'b1;
                state_nxt = BUS;
            end
            BUS: begin
                stall = 1'b1;
                if (bus.bus_ack || timeout) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Lane select from the latched offset, then sign/zero extension.
    always_comb begin
        case (l_off)
            2'd0:    ld_b = bus.bus_rdata[7:0];
            2'd1:    ld_b = bus.bus_rdata[15:8];
            2'd2:    ld_b = bus.bus_rdata[23:16];
            default: ld_b = bus.bus_rdata[31:24];
        endcase
        ld_h = l_off[1] ? bus.bus_rdata[31:16] : bus.bus_rdata[15:0];
        if (l_byte)      ld_ext = {{24{~l_uns & ld_b[7]}}, ld_b};
        else if (l_half) ld_ext = {{16{~l_uns & ld_h[15]}}, ld_h};
        else             ld_ext = bus.bus_rdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            l_we <= 1'b0; l_rd <= 1'b0; l_byte <= 1'b0; l_half <= 1'b0; l_uns <= 1'b0;
            l_off <= 2'b00; err_q <= 1'b0; cnt <= '0;
            addr_q <= '0; wdata_q <= '0; be_q <= '0; rdata_out <= '0;
        end else begin
            case (state)
                IDLE: if (go) begin
                    // A simultaneous read+write request is executed as a store.
                    l_we    <= mem_write;
                    l_rd    <= mem_read & ~mem_write;
                    l_byte  <= byte_op;
                    l_half  <= half;
                    l_uns   <= unsigned_ext;
                    l_off   <= addr[1:0];
                    err_q   <= 1'b0;
                    cnt     <= '0;
                    addr_q  <= {addr[31:2], 2'b00};
                    if (byte_op) begin
                        be_q    <= 4'b0001 << addr[1:0];
                        wdata_q <= {4{wdata[7:0]}};
                    end else if (half) begin
                        be_q    <= 4'b0011 << {addr[1], 1'b0};
                        wdata_q <= {2{wdata[15:0]}};
                    end else begin
                        be_q    <= 4'b1111;
                        wdata_q <= wdata;
                    end
                end
                BUS: begin
                    if (bus.bus_ack) begin
                        if (l_rd) rdata_out <= ld_ext;
                    end else if (timeout) begin
                        rdata_out <= '0;
                        err_q     <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.bus_req   = (state == BUS);
    assign bus.bus_we    = (state == BUS) & l_we;
    assign bus.bus_addr  = addr_q;
    assign bus.bus_be    = be_q;
    assign bus.bus_wdata = wdata_q;
    assign done          = (state == DONE);
    assign bus_err       = (state == DONE) & err_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: loads, stores, misalignment, timeout and async reset.
module tb_mem_access_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_in, mem_read, mem_write, byte_op, half, unsigned_ext;
    logic [31:0] addr, wdata;
    logic        stall, done, misalign, bus_err;
    logic [31:0] rdata_out;
    int checks = 0, failures = 0;

    mem_access_unit_if bif ();

    mem_access_unit #(.TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .mem_read(mem_read),
        .mem_write(mem_write), .byte_op(byte_op), .half(half), .unsigned_ext(unsigned_ext),
        .addr(addr), .wdata(wdata), .stall(stall), .done(done), .rdata_out(rdata_out),
        .misalign(misalign), .bus_err(bus_err), .bus(bif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        valid_in = 0; mem_read = 0; mem_write = 0; byte_op = 0; half = 0;
        unsigned_ext = 0; addr = 0; wdata = 0;
    endtask

    initial begin
        rst_n = 0; idle_inputs();
        bif.bus_ack = 0; bif.bus_rdata = 0;
        @(negedge clk); @(negedge clk);
        chk("rst_stall", stall, 0);   chk("rst_done", done, 0);
        chk("rst_req", bif.bus_req, 0); chk("rst_we", bif.bus_we, 0);
        chk("rst_be", bif.bus_be, 0); chk("rst_addr", bif.bus_addr, 0);
        chk("rst_wdata", bif.bus_wdata, 0); chk("rst_rdata", rdata_out, 0);
        chk("rst_err", bus_err, 0);
        rst_n = 1;

        // lb 0x1003, zero-wait
        @(negedge clk);
        valid_in = 1; mem_read = 1; byte_op = 1; addr = 32'h1003;
        #1 chk("lb_c0_stall", stall, 1); chk("lb_c0_mis", misalign, 0);
        @(negedge clk); idle_inputs();
        bif.bus_ack = 1; bif.bus_rdata = 32'h80FF_FF12;
        #1 chk("lb_c1_req", bif.bus_req, 1); chk("lb_c1_we", bif.bus_we, 0);
        chk("lb_c1_addr", bif.bus_addr, 32'h1000); chk("lb_c1_be", bif.bus_be, 4'b1000);
        chk("lb_c1_stall", stall, 1);
        @(negedge clk); bif.bus_ack = 0;
        #1 chk("lb_c2_done", done, 1); chk("lb_c2_stall", stall, 0);
        chk("lb_c2_rdata", rdata_out, 32'hFFFF_FF80); chk("lb_c2_err", bus_err, 0);
        chk("lb_c2_req", bif.bus_req, 0);
        @(negedge clk);
        #1 chk("lb_c3_done", done, 0);

        // lhu 0x2002, 3 wait states; ack lands on the last countable cycle
        @(negedge clk);
        valid_in = 1; mem_read = 1; half = 1; unsigned_ext = 1; addr = 32'h2002;
        #1 chk("lhu_c0_stall", stall, 1);
        @(negedge clk); idle_inputs();
        #1 chk("lhu_c1_be", bif.bus_be, 4'b1100); chk("lhu_c1_req", bif.bus_req, 1);
        @(negedge clk); #1 chk("lhu_c2_stall", stall, 1);
        @(negedge clk); #1 chk("lhu_c3_stall", stall, 1);
        @(negedge clk); bif.bus_ack = 1; bif.bus_rdata = 32'hBEEF_1234;
        #1 chk("lhu_c4_stall", stall, 1); chk("lhu_c4_req", bif.bus_req, 1);
        @(negedge clk); bif.bus_ack = 0;
        #1 chk("lhu_c5_done", done, 1); chk("lhu_c5_stall", stall, 0);
        chk("lhu_c5_rdata", rdata_out, 32'h0000_BEEF); chk("lhu_c5_err", bus_err, 0);
        @(negedge clk);

        // sb 0x3001
        @(negedge clk);
        valid_in = 1; mem_write = 1; byte_op = 1; addr = 32'h3001; wdata = 32'h0000_00A5;
        #1 chk("sb_c0_stall", stall, 1);
        @(negedge clk); idle_inputs(); bif.bus_ack = 1; bif.bus_rdata = 32'h1111_2222;
        #1 chk("sb_c1_we", bif.bus_we, 1); chk("sb_c1_be", bif.bus_be, 4'b0010);
        chk("sb_c1_wdata", bif.bus_wdata, 32'hA5A5_A5A5); chk("sb_c1_addr", bif.bus_addr, 32'h3000);
        @(negedge clk); bif.bus_ack = 0;
        #1 chk("sb_c2_done", done, 1); chk("sb_c2_rdata", rdata_out, 32'h0000_BEEF);
        chk("sb_c2_err", bus_err, 0);
        @(negedge clk);

        // lw 0x4002 misaligned
        @(negedge clk);
        valid_in = 1; mem_read = 1; addr = 32'h4002;
        #1 chk("mis_c0_flag", misalign, 1); chk("mis_c0_stall", stall, 0);
        chk("mis_c0_req", bif.bus_req, 0);
        @(negedge clk);
        #1 chk("mis_c1_req", bif.bus_req, 0); chk("mis_c1_flag", misalign, 1);
        idle_inputs();
        #1 chk("mis_clear", misalign, 0);

        // lw 0x4000 with no ack: TIMEOUT=4 bus cycles then error
        @(negedge clk);
        valid_in = 1; mem_read = 1; addr = 32'h4000;
        #1 chk("to_c0_stall", stall, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); idle_inputs();
            #1 chk($sformatf("to_bus%0d_req", i), bif.bus_req, 1);
        end
        @(negedge clk);
        #1 chk("to_done", done, 1); chk("to_err", bus_err, 1);
        chk("to_rdata", rdata_out, 0); chk("to_req", bif.bus_req, 0);
        @(negedge clk);
        #1 chk("to_after_done", done, 0); chk("to_after_err", bus_err, 0);

        // reset during a bus wait, then a clean lw
        @(negedge clk);
        valid_in = 1; mem_read = 1; addr = 32'h5000;
        @(negedge clk); idle_inputs();
        #1 chk("rb_c1_req", bif.bus_req, 1);
        @(negedge clk);
        #1 rst_n = 0;
        #1 chk("rb_req_drop", bif.bus_req, 0); chk("rb_stall_drop", stall, 0);
        chk("rb_done", done, 0);
        @(negedge clk); rst_n = 1;
        @(negedge clk);
        #1 chk("rb_idle_req", bif.bus_req, 0);
        valid_in = 1; mem_read = 1; addr = 32'h5004;
        #1 chk("lw_c0_stall", stall, 1);
        @(negedge clk); idle_inputs(); bif.bus_ack = 1; bif.bus_rdata = 32'h1234_5678;
        #1 chk("lw_c1_addr", bif.bus_addr, 32'h5004); chk("lw_c1_be", bif.bus_be, 4'b1111);
        @(negedge clk); bif.bus_ack = 0;
        #1 chk("lw_c2_done", done, 1); chk("lw_c2_rdata", rdata_out, 32'h1234_5678);
        chk("lw_c2_err", bus_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage access controller sitting directly downstream of the EX/MEM pipeline registers. It consumes the latched address, store data and memory control signals (MemWrite, MemtoReg, Byte, Half, UnsignedExt_Mem). It runs one transaction on a req/ack data bus and stalls the pipeline until the access completes. It produces aligned, sign- or zero-extended load data for the MEM/WB stage and flags misaligned accesses and bus timeouts.

## Interface
- TIMEOUT, 16: maximum bus wait cycles before abort; legal range 1..255.
- clk  in  1  pipeline clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- valid_in  in  1  MEM-stage slot holds a live instruction (not a bubble).
- mem_read  in  1  load (MemtoReg from EX/MEM).
- mem_write  in  1  store (MemWrite from EX/MEM).
- byte  in  1  byte access.
- half  in  1  halfword access; byte=half=0 means word.
- unsigned_ext  in  1  zero-extend load result; 0 = sign-extend.
- addr  in  32  effective byte address (ALU result).
- wdata  in  32  store data, right-justified.
- stall  out  1  holds the upstream pipeline registers (EN low).
- done  out  1  one-cycle pulse; the transaction result is valid.
- rdata_out  out  32  extended load result; holds until the next completion.
- misalign  out  1  combinational misaligned-access flag.
- bus_err  out  1  one-cycle pulse with done when the transaction timed out.
- bus_req, bus_we  out  1 each  bus request and write strobe.
- bus_addr  out  32  word-aligned address ({addr[31:2],2'b00}).
- bus_be  out  4  byte enables, little-endian.
- bus_wdata  out  32  lane-replicated store data.
- bus_ack  in  1  slave completion, sampled at the rising edge.
- bus_rdata  in  32  read word, valid when bus_ack=1.

## Operation
- States: IDLE, BUS, DONE.
- access = valid_in & (mem_read | mem_write).
- mis = (half & addr[0]) | (~byte & ~half & (addr[1:0]!=0)).
- misalign = state==IDLE & access & mis.
- IDLE:
  - access & ~mis: stall=1 combinationally; latch addr, control and wdata into internal registers; go to BUS.
  - access & mis: misalign=1, stall=0, no bus activity, stay in IDLE.
  - no access: stall=0.
- BUS:
  - bus_req=1; stall=1.
  - bus_we = latched mem_write.
  - All bus outputs are driven from the latched registers and stay stable until ack.
  - Wait counter clears on entry and increments each BUS cycle without ack.
- BUS exit on bus_ack=1 at an edge: for a read, rdata_out is updated from bus_rdata; go to DONE.
- BUS exit when the counter reaches TIMEOUT-1 with no ack: rdata_out=0, bus_err pulses in DONE, go to DONE.
- If ack and timeout coincide, ack wins and bus_err stays 0.
- DONE: stall=0, done=1, bus_req=0; return to IDLE unconditionally. The pipeline advances on this edge, so the same instruction is never reissued.
- bus_be:
  - byte: 4'b0001<<addr[1:0]
  - half: 4'b0011<<{addr[1],1'b0}
  - word: 4'b1111
- bus_wdata:
  - byte: {4{wdata[7:0]}}
  - half: {2{wdata[15:0]}}
  - word: wdata
- Load extraction: select the byte lane addr[1:0] or halfword lane addr[1]; extend to 32 bits per unsigned_ext. Word loads pass through unchanged.
- Stores leave rdata_out unchanged.
- If mem_read and mem_write are both 1, the access is treated as a store.

## Timing
- Reset (async, any state): go to IDLE; stall=0, done=0, bus_err=0, bus_req=0, bus_we=0, bus_be=0, bus_addr=0, bus_wdata=0, rdata_out=0, counter=0.
- A reset mid-transaction drops bus_req immediately and discards the access.
- Zero-wait access:
  - cycle 0: IDLE, stall=1.
  - cycle 1: BUS, bus_req=1, ack=1.
  - cycle 2: DONE, stall=0, done=1.
  - The pipeline advances at the end of cycle 2.
- N wait states add N BUS cycles.
- A timeout gives exactly TIMEOUT BUS cycles, then DONE.
- Back-to-back accesses: the next access is evaluated in the IDLE cycle after DONE, so the minimum spacing is 3 cycles.
- Inputs are ignored while in BUS or DONE; only the latched copies are used.

## Test plan
- lb, addr=0x1003, bus_rdata=0x80FF_FF12, ack at first BUS cycle -> bus_be=4'b1000, bus_addr=0x1000, rdata_out=0xFFFFFF80, stall high 2 cycles, done in cycle 2.
- lhu, addr=0x2002, ack after 3 wait states, bus_rdata=0xBEEF_1234 -> stall high 5 cycles, rdata_out=0x0000BEEF, bus_err=0.
- sb, addr=0x3001, wdata=0x0000_00A5 -> bus_we=1, bus_be=4'b0010, bus_wdata=0xA5A5A5A5, rdata_out unchanged.
- lw, addr=0x4002 -> misalign=1 in the same cycle, stall=0, bus_req never asserted.
- lw with no ack, TIMEOUT=4 -> bus_req high exactly 4 cycles, then done=1, bus_err=1, rdata_out=0.
- rst_n pulsed low during BUS wait -> bus_req and stall drop at once, state IDLE; a following lw completes normally.
